// File: rtl/afe4490_pkg.sv
// afe4490_pkg: AFE4490 register map, CONTROL0 bit positions, frame sizes and responder FSM states
package afe4490_pkg;
    localparam logic [7:0] CONTROL0      = 8'h00;
    localparam logic [7:0] LED2STC       = 8'h01;
    localparam logic [7:0] LED2ENDC      = 8'h02;
    localparam logic [7:0] LED2LEDSTC    = 8'h03;
    localparam logic [7:0] LED2LEDENDC   = 8'h04;
    localparam logic [7:0] ALED2STC      = 8'h05;
    localparam logic [7:0] ALED2ENDC     = 8'h06;
    localparam logic [7:0] LED1STC       = 8'h07;
    localparam logic [7:0] LED1ENDC      = 8'h08;
    localparam logic [7:0] LED1LEDSTC    = 8'h09;
    localparam logic [7:0] LED1LEDENDC   = 8'h0A;
    localparam logic [7:0] ALED1STC      = 8'h0B;
    localparam logic [7:0] ALED1ENDC     = 8'h0C;
    localparam logic [7:0] LED2CONVST    = 8'h0D;
    localparam logic [7:0] LED2CONVEND   = 8'h0E;
    localparam logic [7:0] ALED2CONVST   = 8'h0F;
    localparam logic [7:0] ALED2CONVEND  = 8'h10;
    localparam logic [7:0] LED1CONVST    = 8'h11;
    localparam logic [7:0] LED1CONVEND   = 8'h12;
    localparam logic [7:0] ALED1CONVST   = 8'h13;
    localparam logic [7:0] ALED1CONVEND  = 8'h14;
    localparam logic [7:0] ADCRSTSTCT0   = 8'h15;
    localparam logic [7:0] ADCRSTENDCT0  = 8'h16;
    localparam logic [7:0] ADCRSTSTCT1   = 8'h17;
    localparam logic [7:0] ADCRSTENDCT1  = 8'h18;
    localparam logic [7:0] ADCRSTSTCT2   = 8'h19;
    localparam logic [7:0] ADCRSTENDCT2  = 8'h1A;
    localparam logic [7:0] ADCRSTSTCT3   = 8'h1B;
    localparam logic [7:0] ADCRSTENDCT3  = 8'h1C;
    localparam logic [7:0] PRPCOUNT      = 8'h1D;
    localparam logic [7:0] CONTROL1      = 8'h1E;
    localparam logic [7:0] SPARE1        = 8'h1F;
    localparam logic [7:0] TIAGAIN       = 8'h20;
    localparam logic [7:0] TIA_AMB_GAIN  = 8'h21;
    localparam logic [7:0] LEDCNTRL      = 8'h22;
    localparam logic [7:0] CONTROL2      = 8'h23;
    localparam logic [7:0] SPARE2        = 8'h24;
    localparam logic [7:0] SPARE3        = 8'h25;
    localparam logic [7:0] SPARE4        = 8'h26;
    localparam logic [7:0] RESERVED1     = 8'h27;
    localparam logic [7:0] RESERVED2     = 8'h28;
    localparam logic [7:0] ALARM         = 8'h29;
    localparam logic [7:0] LED2VAL       = 8'h2A;
    localparam logic [7:0] ALED2VAL      = 8'h2B;
    localparam logic [7:0] LED1VAL       = 8'h2C;
    localparam logic [7:0] ALED1VAL      = 8'h2D;
    localparam logic [7:0] LED2_ALED2VAL = 8'h2E;
    localparam logic [7:0] LED1_ALED1VAL = 8'h2F;
    localparam logic [7:0] DIAG          = 8'h30;
    localparam int SPI_READ    = 0;
    localparam int TIM_CNT_RST = 1;
    localparam int DIAG_EN     = 2;
    localparam int SW_RST      = 3;
    localparam int ADDR_BITS  = 8;
    localparam int DATA_BITS  = 24;
    localparam int FRAME_BITS = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_WAIT_CS} state_e;
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: multi-flop synchronizer for one asynchronous SPI pin with registered edge pulses
//   i_clk, i_rst : system clock, async active-high reset
//   i_d          : asynchronous pin
//   o_q          : synchronized level, aligned with the pulses
//   o_rise/o_fall: one-cycle pulses, STAGES+1 cycles after the pin edge
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
            prev_q <= sync_q[STAGES-1];
            o_rise <= sync_q[STAGES-1] & ~prev_q;
            o_fall <= ~sync_q[STAGES-1] & prev_q;
        end
    end
    assign o_q = prev_q;
endmodule

// File: rtl/afe_spi_responder.sv
// afe_spi_responder: AFE4490 register-file model answering 32-bit mode-0 SPI frames
//   i_sclk/i_cs_n/i_mosi : asynchronous SPI pins from the master
//   o_miso/o_miso_oe     : readback data and its enable
//   i_val_*              : loads the read-only result registers 0x2A..0x30
//   o_wr_*               : strobe, address and data of the last committed SPI write
//   o_spi_read           : CONTROL0 SPI_READ bit
//   o_frame_err          : pulse on a frame cut short by CS
module afe_spi_responder
    import afe4490_pkg::*;
#(
    parameter int REG_LAST    = 'h30,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_miso_oe,
    input  logic        i_val_we,
    input  logic [2:0]  i_val_sel,
    input  logic [23:0] i_val_data,
    output logic        o_wr_strobe,
    output logic [7:0]  o_wr_addr,
    output logic [23:0] o_wr_data,
    output logic        o_spi_read,
    output logic        o_frame_err
);
    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic unused_pins;
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sclk (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk), .o_q(sclk_q), .o_rise(sclk_rise), .o_fall(sclk_fall));
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_cs   (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs_n), .o_q(cs_q),   .o_rise(cs_rise),   .o_fall(cs_fall));
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_mosi (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi), .o_q(mosi_q), .o_rise(mosi_rise), .o_fall(mosi_fall));
    assign unused_pins = ^{sclk_q, mosi_rise, mosi_fall};
    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [7:0]  addr_q;
    logic [22:0] shift_q;
    logic [23:0] out_q;
    logic        rd_q, miso_q, oe_q, wr_strobe_q, frame_err_q;
    logic [7:0]  wr_addr_q;
    logic [23:0] wr_data_q;
    logic [23:0] regs_q [0:REG_LAST];
    logic [23:0] shift_in, rd_word;
    logic [5:0]  val_idx;
    assign shift_in = {shift_q, mosi_q};
    assign rd_word  = addr_q > 8'(REG_LAST) ? '0 : regs_q[addr_q[5:0]];
    assign val_idx  = 6'(LED2VAL) + {3'd0, i_val_sel};
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            shift_q     <= '0;
            out_q       <= '0;
            rd_q        <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i <= REG_LAST; i++) regs_q[i] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            // result port first so a same-cycle SW_RST below overrides it
            if (i_val_we && i_val_sel != 3'd7) regs_q[val_idx] <= i_val_data;
            if (cs_rise) begin
                miso_q      <= 1'b0;
                oe_q        <= 1'b0;
                frame_err_q <= state_q == ST_DATA || (state_q == ST_ADDR && cnt_q != '0);
            end
            if (cs_q) state_q <= ST_IDLE;
            else case (state_q)
                ST_IDLE: if (cs_fall) begin
                    state_q <= ST_ADDR;
                    cnt_q   <= '0;
                end
                ST_ADDR: if (sclk_rise) begin
                    cnt_q   <= cnt_q + 6'd1;
                    shift_q <= shift_in[22:0];
                    if (cnt_q == 6'(ADDR_BITS - 1)) begin
                        addr_q  <= shift_in[7:0];
                        rd_q    <= regs_q[0][SPI_READ] && shift_in[7:0] != CONTROL0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // first fall after the address loads the word, later falls shift it out
                    if (sclk_fall && rd_q) begin
                        oe_q   <= 1'b1;
                        miso_q <= cnt_q == 6'(ADDR_BITS) ? rd_word[23] : out_q[23];
                        out_q  <= cnt_q == 6'(ADDR_BITS) ? {rd_word[22:0], 1'b0} : {out_q[22:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_q   <= cnt_q + 6'd1;
                        shift_q <= shift_in[22:0];
                        if (cnt_q == 6'(FRAME_BITS - 1)) begin
                            state_q <= ST_WAIT_CS;
                            if (!rd_q && addr_q <= ALARM) begin
                                wr_strobe_q <= 1'b1;
                                wr_addr_q   <= addr_q;
                                wr_data_q   <= shift_in;
                                if (addr_q != CONTROL0) regs_q[addr_q[5:0]] <= shift_in;
                                else if (shift_in[SW_RST]) for (int i = 0; i <= REG_LAST; i++) regs_q[i] <= '0;
                                else regs_q[0] <= {21'd0, shift_in[DIAG_EN:SPI_READ]};
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
    assign o_miso      = miso_q;
    assign o_miso_oe   = oe_q;
    assign o_wr_strobe = wr_strobe_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_spi_read  = regs_q[0][SPI_READ];
    assign o_frame_err = frame_err_q;
endmodule

// File: tb/tb_afe_spi_responder.sv
// tb_afe_spi_responder: table-driven frame vectors against hand-computed register-file results
module tb_afe_spi_responder;
    localparam int HALF = 80;
    logic clk = 1'b0, rst = 1'b1;
    logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, miso_oe, wr_strobe, spi_read, frame_err;
    logic val_we = 1'b0;
    logic [2:0] val_sel = '0;
    logic [23:0] val_data = '0, wr_data;
    logic [7:0] wr_addr;
    int checks = 0, errors = 0, cur = -1, n_stb = 0, n_err = 0;
    always #5 clk = ~clk;
    afe_spi_responder dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .o_miso(miso), .o_miso_oe(miso_oe),
        .i_val_we(val_we), .i_val_sel(val_sel), .i_val_data(val_data),
        .o_wr_strobe(wr_strobe), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_spi_read(spi_read), .o_frame_err(frame_err)
    );
    always @(negedge clk) begin
        if (wr_strobe) n_stb++;
        if (frame_err) n_err++;
    end
    task automatic ck(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h want %h", n, cur, act, exp);
        end
    endtask
    task automatic chk_reset();
        ck("rst_miso", 32'(miso), 0);
        ck("rst_oe", 32'(miso_oe), 0);
        ck("rst_stb", 32'(wr_strobe), 0);
        ck("rst_waddr", 32'(wr_addr), 0);
        ck("rst_wdata", 32'(wr_data), 0);
        ck("rst_spi_read", 32'(spi_read), 0);
        ck("rst_err", 32'(frame_err), 0);
    endtask
    task automatic frame(input logic [7:0] a, input logic [23:0] d, input int nb, input int rst_at,
                         output logic [23:0] rx, output int oe_n);
        logic [31:0] w;
        w = {a, d};
        rx = '0;
        oe_n = 0;
        cs_n = 1'b0;
        #(HALF);
        for (int i = 0; i < nb; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                chk_reset();
                rst = 1'b0;
            end
            mosi = i < 32 ? w[31-i] : 1'b1;
            #(HALF);
            if (i >= 8 && i < 32) rx = {rx[22:0], miso};
            if (i < 32 && miso_oe) oe_n++;
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
        #(HALF);
        cs_n = 1'b1;
        #(2 * HALF);
    endtask
    typedef struct {
        logic        vwe;
        logic [2:0]  vsel;
        logic [23:0] vdata;
        logic [7:0]  a;
        logic [23:0] d;
        int          nb;
        int          rst_at;
        int          e_stb;
        int          e_err;
        logic [7:0]  e_wa;
        logic [23:0] e_wd;
        logic        e_sr;
        logic        rd;
        logic [23:0] e_rx;
    } vec_t;
    vec_t tv [25];
    initial begin
        logic [23:0] rx;
        int oe_n, s0, e0;
        tv[0]  = '{1'b0, 3'd0, 24'h0,      8'h01, 24'h00ABCD, 32, -1, 1, 0, 8'h01, 24'h00ABCD, 1'b0, 1'b0, 24'h0};
        tv[1]  = '{1'b0, 3'd0, 24'h0,      8'h00, 24'h000001, 32, -1, 1, 0, 8'h00, 24'h000001, 1'b1, 1'b0, 24'h0};
        tv[2]  = '{1'b0, 3'd0, 24'h0,      8'h01, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h00ABCD};
        tv[3]  = '{1'b1, 3'd2, 24'h123456, 8'h2C, 24'h000000, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h123456};
        tv[4]  = '{1'b0, 3'd0, 24'h0,      8'h00, 24'h000000, 32, -1, 1, 0, 8'h00, 24'h000000, 1'b0, 1'b0, 24'h0};
        tv[5]  = '{1'b0, 3'd0, 24'h0,      8'h2C, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000000, 1'b0, 1'b0, 24'h0};
        tv[6]  = '{1'b0, 3'd0, 24'h0,      8'h05, 24'h000777, 32, -1, 1, 0, 8'h05, 24'h000777, 1'b0, 1'b0, 24'h0};
        tv[7]  = '{1'b0, 3'd0, 24'h0,      8'h05, 24'h123456, 20, -1, 0, 1, 8'h05, 24'h000777, 1'b0, 1'b0, 24'h0};
        tv[8]  = '{1'b0, 3'd0, 24'h0,      8'h07, 24'h000055, 40, -1, 1, 0, 8'h07, 24'h000055, 1'b0, 1'b0, 24'h0};
        tv[9]  = '{1'b0, 3'd0, 24'h0,      8'h00, 24'h000001, 32, -1, 1, 0, 8'h00, 24'h000001, 1'b1, 1'b0, 24'h0};
        tv[10] = '{1'b0, 3'd0, 24'h0,      8'h2C, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h123456};
        tv[11] = '{1'b0, 3'd0, 24'h0,      8'h05, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h000777};
        tv[12] = '{1'b0, 3'd0, 24'h0,      8'h07, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h000055};
        tv[13] = '{1'b0, 3'd0, 24'h0,      8'h3F, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h000000};
        tv[14] = '{1'b0, 3'd0, 24'h0,      8'h00, 24'h000008, 32, -1, 1, 0, 8'h00, 24'h000008, 1'b0, 1'b0, 24'h0};
        tv[15] = '{1'b0, 3'd0, 24'h0,      8'h00, 24'h000001, 32, -1, 1, 0, 8'h00, 24'h000001, 1'b1, 1'b0, 24'h0};
        tv[16] = '{1'b0, 3'd0, 24'h0,      8'h01, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h000000};
        tv[17] = '{1'b0, 3'd0, 24'h0,      8'h05, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h000000};
        tv[18] = '{1'b0, 3'd0, 24'h0,      8'h2C, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h000000};
        tv[19] = '{1'b0, 3'd0, 24'h0,      8'h07, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h000000};
        tv[20] = '{1'b0, 3'd0, 24'h0,      8'h00, 24'h000001, 32, 16, 0, 0, 8'h00, 24'h000000, 1'b0, 1'b0, 24'h0};
        tv[21] = '{1'b0, 3'd0, 24'h0,      8'h09, 24'h000AAA, 32, -1, 1, 0, 8'h09, 24'h000AAA, 1'b0, 1'b0, 24'h0};
        tv[22] = '{1'b0, 3'd0, 24'h0,      8'h00, 24'h000001, 32, -1, 1, 0, 8'h00, 24'h000001, 1'b1, 1'b0, 24'h0};
        tv[23] = '{1'b0, 3'd0, 24'h0,      8'h09, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h000AAA};
        tv[24] = '{1'b1, 3'd6, 24'h654321, 8'h30, 24'hFFFFFF, 32, -1, 0, 0, 8'h00, 24'h000001, 1'b1, 1'b1, 24'h654321};
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_reset();
        for (int k = 0; k < 25; k++) begin
            cur = k;
            if (tv[k].vwe) begin
                @(negedge clk);
                val_we = 1'b1;
                val_sel = tv[k].vsel;
                val_data = tv[k].vdata;
                @(negedge clk);
                val_we = 1'b0;
            end
            s0 = n_stb;
            e0 = n_err;
            frame(tv[k].a, tv[k].d, tv[k].nb, tv[k].rst_at, rx, oe_n);
            ck("strobes", 32'(n_stb - s0), 32'(tv[k].e_stb));
            ck("frame_errs", 32'(n_err - e0), 32'(tv[k].e_err));
            ck("wr_addr", 32'(wr_addr), 32'(tv[k].e_wa));
            ck("wr_data", 32'(wr_data), 32'(tv[k].e_wd));
            ck("spi_read", 32'(spi_read), 32'(tv[k].e_sr));
            ck("oe_bits", 32'(oe_n), tv[k].rd ? 32'd24 : 32'd0);
            ck("idle_oe_miso", {30'd0, miso_oe, miso}, 32'd0);
            if (tv[k].rd) ck("miso_word", 32'(rx), 32'(tv[k].e_rx));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
